cache_axi_bridge: RTL and testbench

CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge
Interface
REQ-001 LINE_BEATS, 4, 32-bit beats per cache line; AXI len for a line transfer is LINE_BEATS-1.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 rd_req  in  1  cache read request.
REQ-005 rd_type  in  3  000 byte, 001 half, 010 word, 100 line.
REQ-006 rd_addr  in  32  read address.
REQ-007 rd_rdy  out  1  read request accepted this cycle if rd_req high.
REQ-008 ret_valid  out  1  read beat valid to cache.
REQ-009 ret_last  out  1  final read beat.
REQ-010 ret_data  out  32  read beat data.
REQ-011 wr_req  in  1  cache write request (single-cycle pulse).
REQ-012 wr_type  in  3  encoding as rd_type.
REQ-013 wr_addr  in  32  write address.
REQ-014 wr_strb  in  4  byte enables, non-line writes only.
REQ-015 wr_data  in  128  line data, word0 in [31:0]; non-line uses [31:0].
REQ-016 wr_rdy  out  1  write request accepted this cycle if wr_req high.
REQ-017 araddr  out  32  AXI read address.
REQ-018 arlen  out  8  AXI read burst length-1.
REQ-019 arvalid  out  1  AXI AR valid.
REQ-020 arready  in  1  AXI AR ready.
REQ-021 rdata  in  32  AXI read data.
REQ-022 rlast  in  1  AXI last read beat.
REQ-023 rvalid  in  1  AXI R valid.
REQ-024 rready  out  1  AXI R ready.
REQ-025 awaddr  out  32  AXI write address.
REQ-026 awlen  out  8  AXI write burst length-1.
REQ-027 awvalid  out  1  AXI AW valid.
REQ-028 awready  in  1  AXI AW ready.
REQ-029 wdata  out  32  AXI write data.
REQ-030 wstrb  out  4  AXI write strobes.
REQ-031 wlast  out  1  AXI last write beat.
REQ-032 wvalid  out  1  AXI W valid.
REQ-033 wready  in  1  AXI W ready.
REQ-034 bvalid  in  1  AXI B valid.
REQ-035 bready  out  1  AXI B ready.
Function
REQ-036 Read FSM R_IDLE->R_AR on rd_req&&rd_rdy (latch addr/len) ->R_DATA on arvalid&&arready ->R_IDLE on rvalid&&rready&&rlast; rd_rdy=R_IDLE and no conflict (REQ-040).
REQ-037 Line: araddr={addr[31:4],4'h0}, arlen=3; byte/half/word: single word beat, araddr={addr[31:2],2'b00}, arlen=0; arvalid=R_AR, rready=R_DATA.
REQ-038 ret_valid=rvalid&&R_DATA, ret_data=rdata, ret_last=rlast, combinational; first ret_valid no earlier than 2 cycles after acceptance.
REQ-039 Write FSM W_IDLE->W_AW (latch addr, 128-bit data, strb, len; beat=0) ->W_DATA on awready ->W_RESP after wlast handshake ->W_IDLE on bvalid; wr_rdy=W_IDLE; bready=W_RESP.
REQ-040 Read to line matching a pending write (FSM not W_IDLE) or same-cycle accepted wr_req: rd_rdy=0 until write returns W_IDLE; different lines proceed concurrently.
REQ-041 W_DATA: wdata=buffer word[beat], wstrb=4'hF for line else latched strb, wlast=(beat==len); beat 2-bit, increments only on wvalid&&wready.
REQ-042 AXI valids never deassert before handshake; address/data stable while valid and not ready.
Reset
REQ-043 resetn low: both FSMs idle immediately, arvalid/awvalid/wvalid/rready/bready/ret_valid=0, rd_rdy=wr_rdy=1 after release; in-flight transactions abandoned, buffers undefined.
Structure
REQ-044 Shared package holds FSM encodings, type codes (TYPE_LINE=3'b100) and LINE_BEATS; write line buffer+beat counter natural as sub-module cache_axi_wbuf.
Verification
REQ-045 rd_req line 0x1C000010, arready after 2 cycles, 4 beats 0xA0..0xA3 -> araddr 0x1C000010, arlen 3, ret_last only on 0xA3.
REQ-046 wr_req line 0x00001230, data words 0x11,0x22,0x33,0x44, wready toggling -> wdata order 0x11..0x44, wlast on 4th, wr_rdy=1 after bvalid.
REQ-047 wr_req line 0x2000 pending, rd_req 0x2004 -> rd_rdy 0 until bvalid; rd_req 0x3000 same time accepted at once.
REQ-048 resetn pulled low during W_DATA beat 2 -> all valids 0 asynchronously, next wr_req restarts at beat 0.

---
 rtl/cache_axi_bridge_pkg.sv | 46 ++++
 rtl/cache_axi_wbuf.sv | 45 ++++
 rtl/cache_axi_bridge.sv | 138 +++++++++++++
 tb/tb_cache_axi_bridge.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_axi_bridge_pkg.sv
// Shared types, constants and address helpers for the cache-to-AXI bridge.
package cache_axi_bridge_pkg;

  localparam int unsigned LINE_BEATS = 4;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned STRB_W     = WORD_W / 8;
  localparam int unsigned LINE_W     = LINE_BEATS * WORD_W;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned TYPE_W     = 3;
  localparam int unsigned BEAT_W     = $clog2(LINE_BEATS);
  localparam int unsigned OFS_W      = $clog2(LINE_W / 8);

  localparam logic [TYPE_W-1:0] TYPE_BYTE = 3'b000;
  localparam logic [TYPE_W-1:0] TYPE_HALF = 3'b001;
  localparam logic [TYPE_W-1:0] TYPE_WORD = 3'b010;
  localparam logic [TYPE_W-1:0] TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } axi_addr_t;

  // Line requests are line-aligned bursts; everything else is one aligned word.
  function automatic axi_addr_t addr_phase(input logic [TYPE_W-1:0] typ,
                                           input logic [ADDR_W-1:0] addr);
    axi_addr_t a;
    if (typ == TYPE_LINE) begin
      a.addr = {addr[ADDR_W-1:OFS_W], OFS_W'(0)};
      a.len  = LEN_W'(LINE_BEATS - 1);
    end else begin
      a.addr = {addr[ADDR_W-1:2], 2'b00};
      a.len  = '0;
    end
    return a;
  endfunction

  function automatic logic same_line(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:OFS_W] == b[ADDR_W-1:OFS_W];
  endfunction

endpackage

// File: rtl/cache_axi_wbuf.sv
// Write line buffer: holds one captured write and steps through its beats.
module cache_axi_wbuf
  import cache_axi_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [TYPE_W-1:0] wr_type,
  input  logic [LINE_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic              advance,
  output logic [WORD_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast
);

  logic [LINE_BEATS-1:0][WORD_W-1:0] line_q;
  logic [STRB_W-1:0]                 strb_q;
  logic [BEAT_W-1:0]                 last_q;
  logic [BEAT_W-1:0]                 beat_q;

  // Payload needs no reset; it is only observed after a load.
  always_ff @(posedge clk) begin
    if (load) begin
      line_q <= wr_data;
      strb_q <= (wr_type == TYPE_LINE) ? '1 : wr_strb;
      last_q <= (wr_type == TYPE_LINE) ? BEAT_W'(LINE_BEATS - 1) : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_q <= '0;
    end else if (load) begin
      beat_q <= '0;
    end else if (advance) begin
      beat_q <= beat_q + BEAT_W'(1);
    end
  end

  assign wdata = line_q[beat_q];
  assign wstrb = strb_q;
  assign wlast = (beat_q == last_q);

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache-side read/write request port to AXI master, with independent read and write FSMs.
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              rd_req,
  input  logic [TYPE_W-1:0] rd_type,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_rdy,
  output logic              ret_valid,
  output logic              ret_last,
  output logic [WORD_W-1:0] ret_data,
  input  logic              wr_req,
  input  logic [TYPE_W-1:0] wr_type,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic [LINE_W-1:0] wr_data,
  output logic              wr_rdy,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic              arvalid,
  input  logic              arready,
  input  logic [WORD_W-1:0] rdata,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [LEN_W-1:0]  awlen,
  output logic              awvalid,
  input  logic              awready,
  output logic [WORD_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;
  axi_addr_t ar_q, aw_q;
  logic      rd_conflict;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_req && rd_rdy) ar_q <= addr_phase(rd_type, rd_addr);
    if (wr_req && wr_rdy) aw_q <= addr_phase(wr_type, wr_addr);
  end

  // A read may not overtake a write to the same line, pending or arriving now.
  always_comb begin
    rd_conflict = 1'b0;
    if (wr_state_q != W_IDLE && same_line(rd_addr, aw_q.addr)) rd_conflict = 1'b1;
    if (wr_req && wr_state_q == W_IDLE && same_line(rd_addr, wr_addr)) rd_conflict = 1'b1;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_rdy     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        rd_rdy = !rd_conflict;
        if (rd_req && !rd_conflict) rd_state_d = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_rdy     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        wr_rdy = 1'b1;
        if (wr_req) wr_state_d = W_AW;
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) wr_state_d = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        if (wready && wlast) wr_state_d = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  assign araddr    = ar_q.addr;
  assign arlen     = ar_q.len;
  assign awaddr    = aw_q.addr;
  assign awlen     = aw_q.len;
  assign ret_valid = rvalid && (rd_state_q == R_DATA);
  assign ret_data  = rdata;
  assign ret_last  = rlast;

  cache_axi_wbuf u_wbuf (
    .clk     (clk),
    .resetn  (resetn),
    .load    (wr_req && wr_rdy),
    .wr_type (wr_type),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .advance (wvalid && wready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast)
  );

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: vector tables for read/write transfers plus hand sequences.
module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         resetn;
  logic         rd_req, wr_req;
  logic [2:0]   rd_type, wr_type;
  logic [31:0]  rd_addr, wr_addr;
  logic         rd_rdy, wr_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic [3:0]   wr_strb;
  logic [127:0] wr_data;
  logic [31:0]  araddr, awaddr, rdata, wdata;
  logic [7:0]   arlen, awlen;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]   wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  cache_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_strb(wr_strb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "bench timed out");
  end

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] exp_araddr;
    int          exp_len;
    int          ar_delay;
    logic [31:0] base;
  } rd_vec_t;

  typedef struct {
    logic [2:0]   typ;
    logic [31:0]  addr;
    logic [3:0]   strb;
    logic [127:0] data;
    logic [31:0]  exp_awaddr;
    int           exp_len;
    logic [3:0]   exp_wstrb;
    bit           toggle;
  } wr_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic rd_accept(input logic [2:0] typ, input logic [31:0] addr);
    rd_req = 1'b1; rd_type = typ; rd_addr = addr;
    #1 chk("rd_rdy_accept", rd_rdy, 1);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic ar_phase(input logic [31:0] exp_addr, input int exp_len, input int delay);
    #1;
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, exp_addr);
    chk("arlen", arlen, 32'(exp_len));
    rvalid = 1'b1;
    #1 chk("ret_valid_in_ar", ret_valid, 0);
    rvalid = 1'b0;
    repeat (delay) begin
      @(negedge clk);
      #1;
      chk("arvalid_hold", arvalid, 1);
      chk("araddr_hold", araddr, exp_addr);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
  endtask

  task automatic r_phase(input int len, input logic [31:0] base);
    #1 chk("rready", rready, 1);
    for (int i = 0; i <= len; i++) begin
      rvalid = 1'b1; rdata = base + 32'(i); rlast = (i == len);
      #1;
      chk("ret_valid", ret_valid, 1);
      chk("ret_data", ret_data, base + 32'(i));
      chk("ret_last", ret_last, 32'(i == len));
      @(negedge clk);
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    chk("ret_valid_done", ret_valid, 0);
    chk("rready_done", rready, 0);
  endtask

  task automatic wr_accept(input logic [2:0] typ, input logic [31:0] addr,
                           input logic [3:0] strb, input logic [127:0] data);
    wr_req = 1'b1; wr_type = typ; wr_addr = addr; wr_strb = strb; wr_data = data;
    #1 chk("wr_rdy_accept", wr_rdy, 1);
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  task automatic aw_phase(input logic [31:0] exp_addr, input int exp_len);
    #1;
    chk("awvalid", awvalid, 1);
    chk("awaddr", awaddr, exp_addr);
    chk("awlen", awlen, 32'(exp_len));
    chk("wr_rdy_busy", wr_rdy, 0);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
  endtask

  task automatic w_phase(input int len, input logic [127:0] data,
                         input logic [3:0] exp_strb, input bit toggle);
    int i = 0;
    int cyc = 0;
    while (i <= len && cyc < 64) begin
      wready = toggle ? (cyc % 2 == 1) : 1'b1;
      #1;
      chk("wvalid", wvalid, 1);
      chk("wdata", wdata, data[32*i +: 32]);
      chk("wstrb", 32'(wstrb), 32'(exp_strb));
      chk("wlast", wlast, 32'(i == len));
      if (wready) i++;
      @(negedge clk);
      cyc++;
    end
    if (i <= len) chk("w_beats_timeout", 32'(i), 32'(len + 1));
    wready = 1'b0;
  endtask

  task automatic b_phase();
    #1;
    chk("bready", bready, 1);
    chk("wvalid_resp", wvalid, 0);
    chk("wr_rdy_resp", wr_rdy, 0);
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    chk("wr_rdy_after_b", wr_rdy, 1);
    chk("bready_after_b", bready, 0);
  endtask

  rd_vec_t rd_tab [4];
  wr_vec_t wr_tab [4];
  logic [127:0] d_a, d_b, d_c;

  initial begin
    rd_tab[0] = '{3'b100, 32'h1C000010, 32'h1C000010, 3, 2, 32'h000000A0};
    rd_tab[1] = '{3'b000, 32'h1C000013, 32'h1C000010, 0, 0, 32'h00000055};
    rd_tab[2] = '{3'b001, 32'h00000106, 32'h00000104, 0, 1, 32'h12340000};
    rd_tab[3] = '{3'b100, 32'h8000003C, 32'h80000030, 3, 0, 32'hFFFFFFFE};
    wr_tab[0] = '{3'b100, 32'h00001230, 4'h0, 128'h00000044_00000033_00000022_00000011,
                  32'h00001230, 3, 4'hF, 1'b1};
    wr_tab[1] = '{3'b000, 32'h00000501, 4'h2, 128'h0_DEADBEEF, 32'h00000500, 0, 4'h2, 1'b0};
    wr_tab[2] = '{3'b010, 32'h00004008, 4'hF, 128'h0_CAFEF00D, 32'h00004008, 0, 4'hF, 1'b1};
    wr_tab[3] = '{3'b001, 32'h00007FFE, 4'hC, 128'h0_5A5A0000, 32'h00007FFC, 0, 4'hC, 1'b0};
    d_a = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    d_b = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    d_c = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;

    resetn = 1'b0;
    rd_req = 0; rd_type = 0; rd_addr = 0;
    wr_req = 0; wr_type = 0; wr_addr = 0; wr_strb = 0; wr_data = '0;
    arready = 0; rdata = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;
    #3;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_ret_valid", ret_valid, 0);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_rd_rdy", rd_rdy, 1);
    chk("rst_wr_rdy", wr_rdy, 1);
    @(negedge clk);

    foreach (rd_tab[k]) begin
      rd_accept(rd_tab[k].typ, rd_tab[k].addr);
      ar_phase(rd_tab[k].exp_araddr, rd_tab[k].exp_len, rd_tab[k].ar_delay);
      r_phase(rd_tab[k].exp_len, rd_tab[k].base);
      @(negedge clk);
    end

    foreach (wr_tab[k]) begin
      wr_accept(wr_tab[k].typ, wr_tab[k].addr, wr_tab[k].strb, wr_tab[k].data);
      aw_phase(wr_tab[k].exp_awaddr, wr_tab[k].exp_len);
      w_phase(wr_tab[k].exp_len, wr_tab[k].data, wr_tab[k].exp_wstrb, wr_tab[k].toggle);
      b_phase();
      @(negedge clk);
    end

    // Same-line read held off by a write; other-line read proceeds meanwhile.
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h00002000; wr_strb = 4'h0; wr_data = d_a;
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h00002004;
    #1;
    chk("wr_rdy_conflict", wr_rdy, 1);
    chk("rd_block_same_cycle", rd_rdy, 0);
    @(negedge clk);
    wr_req = 1'b0;
    #1 chk("rd_block_pending", rd_rdy, 0);
    rd_addr = 32'h00003000;
    #1 chk("rd_other_line", rd_rdy, 1);
    @(negedge clk);
    rd_req = 1'b0;
    ar_phase(32'h00003000, 0, 0);
    r_phase(0, 32'h000000B0);
    chk("awvalid_hold", awvalid, 1);
    chk("awaddr_hold", awaddr, 32'h00002000);
    aw_phase(32'h00002000, 3);
    w_phase(3, d_a, 4'hF, 1'b0);
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h00002004;
    #1 chk("rd_block_resp", rd_rdy, 0);
    b_phase();
    chk("rd_unblock", rd_rdy, 1);
    @(negedge clk);
    rd_req = 1'b0;
    ar_phase(32'h00002004, 0, 0);
    r_phase(0, 32'h000000C0);
    @(negedge clk);

    // Reset in the middle of a line write, then a clean restart.
    wr_accept(3'b100, 32'h00005000, 4'h0, d_b);
    aw_phase(32'h00005000, 3);
    wready = 1'b1;
    @(negedge clk); @(negedge clk);
    wready = 1'b0;
    #1;
    chk("mid_wvalid", wvalid, 1);
    chk("mid_wdata_beat2", wdata, 32'hB2B2B2B2);
    #1 resetn = 1'b0;
    #1;
    chk("arst_wvalid", wvalid, 0);
    chk("arst_awvalid", awvalid, 0);
    chk("arst_arvalid", arvalid, 0);
    chk("arst_rready", rready, 0);
    chk("arst_bready", bready, 0);
    chk("arst_ret_valid", ret_valid, 0);
    chk("arst_wr_rdy", wr_rdy, 1);
    chk("arst_rd_rdy", rd_rdy, 1);
    #1 resetn = 1'b1;
    @(negedge clk);
    wr_accept(3'b100, 32'h00006000, 4'h0, d_c);
    aw_phase(32'h00006000, 3);
    w_phase(3, d_c, 4'hF, 1'b0);
    b_phase();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
